seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
- Parametrised time-multiplexed driver for a common-anode multi-digit 7-segment display.
- Supersedes the fixed 4-digit display scanner. Generalised to NUM_DIGITS digits of SEG_W segments.
- Uses an internal clock-enable tick instead of a derived clock.
- Adds per-digit blanking, PWM brightness control, an anti-ghosting guard interval and a scan freeze.
- Sits between the calculator's digit encoders and the board pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- SEG_W, 8, bits per digit pattern (7 segments plus DP), active-low.
- CLK_HZ, 100000000, input clock frequency.
- REFRESH_HZ, 1000, digit-slot rate; DIV = CLK_HZ/REFRESH_HZ cycles per slot; DIV must be >= GUARD+2.
- GUARD, 16, cycles at the start of each slot with all digits disabled.
- BRIGHT_W, 4, brightness code width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- digits  in  NUM_DIGITS*SEG_W  digit patterns; digit i at [i*SEG_W +: SEG_W]; digit 0 is rightmost.
- blank_mask  in  NUM_DIGITS  bit i = 1 forces digit i dark.
- brightness  in  BRIGHT_W  0 = dark, all-ones = full on.
- scan_en  in  1  1 = scan; 0 = freeze index and blank the display.
- to7Segment  out  SEG_W  segment drive, active-low.
- enable  out  NUM_DIGITS  digit enables, active-low, at most one bit low.
- slot_tick  out  1  one-cycle pulse at each digit advance.

Behaviour:
- Reset (async assert; released synchronously by the clk domain):
  - div_cnt=0, idx=0, pwm_cnt=0, slot_tick=0.
  - to7Segment = all ones; enable = all ones.
  - Asserting rst mid-slot blanks the outputs immediately, without waiting for a clock.
- Divider:
  - div_cnt counts 0..DIV-1 while scan_en=1, then wraps to 0.
  - On the cycle div_cnt==DIV-1: idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1, and the registered slot_tick = 1 on the next cycle.
- scan_en=0:
  - div_cnt and idx hold; pwm_cnt keeps running.
  - Outputs are blanked from the next clock.
  - On re-enable, the slot resumes at the held div_cnt.
- PWM:
  - pwm_cnt is a free-running BRIGHT_W-bit counter, incremented every clock and wrapping.
  - lit = (brightness == all-ones) || (pwm_cnt < brightness).
  - brightness=0 means never lit.
- Digit on condition: scan_en && !blank_mask[idx] && div_cnt >= GUARD && lit.
- Outputs (registered, 1-cycle latency from internal state and inputs):
  - On: enable = all ones except bit idx = 0; to7Segment = digits[idx].
  - Off: enable = all ones; to7Segment = all ones.
- Guard: enable stays high for div_cnt 0..GUARD-1 of every slot, which prevents ghosting during the idx change.
- Inputs digits, blank_mask and brightness are sampled every cycle; changes take effect on the next registered output.
- Width rules:
  - idx width = clog2(NUM_DIGITS), minimum 1.
  - div_cnt width = clog2(DIV).
  - No wrap other than the explicit modulo compares above.

Optional Feature:
- Macro: SEVEN_SEG_BLINK_EN.
- Enabled:
  - Extra input blink_mask [NUM_DIGITS] and parameter BLINK_SLOTS (default 250).
  - A blink phase toggles every BLINK_SLOTS slot_ticks; the phase resets to 0, meaning visible.
  - While the phase is 1, digits with blink_mask[i]=1 are treated as blanked.
- Disabled: the port and logic are absent, and behaviour is exactly as above.

Test Plan:
Bench parameters: CLK_HZ=1000, REFRESH_HZ=100 (DIV=10), GUARD=2, NUM_DIGITS=4, BRIGHT_W=4.
- Reset release, digits={8'hC0,8'hF9,8'hA4,8'hB0}, brightness=4'hF, scan_en=1:
  - enable=4'b1111 for the first 3 cycles.
  - Then enable=4'b1110 with to7Segment=8'hB0 until the slot ends.
  - slot_tick pulses every 10 cycles.
  - Index order 0,1,2,3,0 (wrap).
- blank_mask=4'b0100: during slot 2, enable=4'b1111 and to7Segment=8'hFF for all 10 cycles; other slots are unchanged.
- brightness=0 -> enable stays 4'b1111 forever. brightness=4'h8 -> within the post-guard window, enable is low only on cycles with pwm_cnt<8.
- scan_en dropped mid-slot 1:
  - Next cycle: outputs blank; idx and div_cnt frozen.
  - Raised 20 cycles later: slot 1 resumes and completes its remaining cycles.
- rst pulsed asynchronously between clock edges during slot 3: enable=4'b1111 and to7Segment=8'hFF immediately; after release, the scan restarts at idx 0.
- With SEVEN_SEG_BLINK_EN, BLINK_SLOTS=2, blink_mask=4'b0001: digit 0 lit for 2 slots, dark for 2 slots, repeating.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode 7-segment scanner with guard, PWM and freeze.
// Optional blink support enabled by defining SEVEN_SEG_BLINK_EN.
`timescale 1ns/1ps
module seven_seg_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SEG_W      = 8,
  parameter int CLK_HZ     = 100000000,
  parameter int REFRESH_HZ = 1000,
  parameter int GUARD      = 16,
  parameter int BRIGHT_W   = 4
`ifdef SEVEN_SEG_BLINK_EN
  ,
  parameter int BLINK_SLOTS = 250
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_DIGITS*SEG_W-1:0] digits,
  input  logic [NUM_DIGITS-1:0]       blank_mask,
  input  logic [BRIGHT_W-1:0]         brightness,
  input  logic                        scan_en,
`ifdef SEVEN_SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]       blink_mask,
`endif
  output logic [SEG_W-1:0]            to7Segment,
  output logic [NUM_DIGITS-1:0]       enable,
  output logic                        slot_tick
);

  localparam int DIV   = CLK_HZ / REFRESH_HZ;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] GUARD_V  = DIV_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_D = NUM_DIGITS'(1);

  logic [DIV_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    idx;
  logic [BRIGHT_W-1:0] pwm_cnt;
  logic                lit;
  logic                slot_end;
  logic                dark;
  logic                digit_on;
  logic [SEG_W-1:0]    cur_seg;

`ifdef SEVEN_SEG_BLINK_EN
  localparam int BL_W = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_SLOTS - 1);

  logic [BL_W-1:0] blink_cnt;
  logic            blink_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (slot_end) begin
      if (blink_cnt == BL_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign dark = blank_mask[idx] || (blink_phase && blink_mask[idx]);
`else
  assign dark = blank_mask[idx];
`endif

  assign lit      = (&brightness) || (pwm_cnt < brightness);
  assign slot_end = scan_en && (div_cnt == DIV_LAST);
  assign cur_seg  = digits[int'(idx)*SEG_W +: SEG_W];
  // The guard window keeps every anode off while idx settles.
  assign digit_on = scan_en && !dark && (div_cnt >= GUARD_V) && lit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      idx        <= '0;
      pwm_cnt    <= '0;
      slot_tick  <= 1'b0;
      to7Segment <= '1;
      enable     <= '1;
    end else begin
      pwm_cnt   <= pwm_cnt + 1'b1;
      slot_tick <= slot_end;
      if (scan_en) begin
        if (slot_end) begin
          div_cnt <= '0;
          idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
      if (digit_on) begin
        enable     <= ~(ONE_D << idx);
        to7Segment <= cur_seg;
      end else begin
        enable     <= '1;
        to7Segment <= '1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with DIV=10, GUARD=2, 4 digits.
`timescale 1ns/1ps
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] digits = {8'hC0, 8'hF9, 8'hA4, 8'hB0};
  logic [3:0]  blank_mask = 4'b0000;
  logic [3:0]  brightness = 4'hF;
  logic        scan_en = 1'b1;
`ifdef SEVEN_SEG_BLINK_EN
  logic [3:0]  blink_mask = 4'b0000;
`endif
  logic [7:0]  to7Segment;
  logic [3:0]  enable;
  logic        slot_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS(4),
    .SEG_W(8),
    .CLK_HZ(1000),
    .REFRESH_HZ(100),
    .GUARD(2),
    .BRIGHT_W(4)
`ifdef SEVEN_SEG_BLINK_EN
    ,
    .BLINK_SLOTS(2)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .digits(digits),
    .blank_mask(blank_mask),
    .brightness(brightness),
    .scan_en(scan_en),
`ifdef SEVEN_SEG_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .to7Segment(to7Segment),
    .enable(enable),
    .slot_tick(slot_tick)
  );

  task automatic chk(input string tag, input int n,
                     input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step %0d observed %h expected %h", tag, n, obs, exp);
    end
  endtask

  task automatic chk_blank(input string tag, input int n);
    chk({tag, "_en"}, n, {4'h0, enable}, 8'h0F);
    chk({tag, "_seg"}, n, to7Segment, 8'hFF);
    chk({tag, "_tick"}, n, {7'd0, slot_tick}, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk_blank("reset", 0);
    rst = 1'b0;
  endtask

  // Edge n after reset release shows slot (n-1)/10 at div (n-1)%10.
  task automatic run(input int n0, input int cnt,
                     input logic [3:0] mask, input logic [3:0] br);
    int d, k, s, p;
    logic on;
    logic [3:0] e_en;
    logic [7:0] e_seg;
    blank_mask = mask;
    brightness = br;
    for (int n = n0; n < n0 + cnt; n++) begin
      @(posedge clk);
      #1;
      d  = (n - 1) % 10;
      k  = (n - 1) / 10;
      s  = k % 4;
      p  = (n - 1) % 16;
      on = (d >= 2) && !mask[s] && (br == 4'hF || p < int'(br));
`ifdef SEVEN_SEG_BLINK_EN
      if (blink_mask[s] && ((k / 2) % 2) == 1) on = 1'b0;
`endif
      e_en  = on ? ~(4'b0001 << s) : 4'hF;
      e_seg = on ? digits[s*8 +: 8] : 8'hFF;
      chk("enable", n, {4'h0, enable}, {4'h0, e_en});
      chk("seg", n, to7Segment, e_seg);
      chk("tick", n, {7'd0, slot_tick}, {7'd0, (n % 10) == 0});
    end
  endtask

  initial begin
    // Plain scan with wrap back to digit 0
    do_reset();
    run(1, 45, 4'b0000, 4'hF);

    // Slot 2 blanked by mask
    do_reset();
    run(1, 45, 4'b0100, 4'hF);

    // Dark and half brightness
    do_reset();
    run(1, 40, 4'b0000, 4'h0);
    do_reset();
    run(1, 40, 4'b0000, 4'h8);

    // Freeze mid-slot 1, then resume where it stopped
    do_reset();
    run(1, 15, 4'b0000, 4'hF);
    scan_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk_blank("frozen", i);
    end
    scan_en = 1'b1;
    run(16, 30, 4'b0000, 4'hF);

    // Asynchronous reset between edges during slot 3
    do_reset();
    run(1, 35, 4'b0000, 4'hF);
    #2;
    rst = 1'b1;
    #1;
    chk_blank("async_rst", 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    run(1, 12, 4'b0000, 4'hF);

`ifdef SEVEN_SEG_BLINK_EN
    do_reset();
    blink_mask = 4'b0001;
    run(1, 85, 4'b0000, 4'hF);
    blink_mask = 4'b0000;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
